uart_tx_arbiter: RTL and testbench

Shares one RS232 transmit byte channel (rs232_0 TXD serializer) between two byte-stream requesters, e.g. the Nios II console path and a hardware debug/telemetry source. Uses packet-level round-robin arbitration: a granted requester keeps the channel until it sends its last byte or hits a burst cap. Uses a valid/ready handshake on both sides and sits between the requesters and the UART transmitter in the clk_clk domain.

---
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmit byte channel between
// two valid/ready byte requesters; the owner keeps the channel until last or burst cap.
module uart_tx_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             rr_last, rr_last_nxt;
  logic             xfer;
  logic             xfer_last;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      rr_last   <= 1'b1;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      rr_last   <= rr_last_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    rr_last_nxt   = rr_last;
    grant         = 2'b00;
    busy          = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = '0;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    xfer          = 1'b0;
    xfer_last     = 1'b0;

    case (state)
      IDLE: begin
        // On a tie the requester that was not granted most recently wins.
        if (req0_valid && (!req1_valid || rr_last)) begin
          state_nxt     = GRANT0;
          burst_cnt_nxt = '0;
          rr_last_nxt   = 1'b0;
        end else if (req1_valid) begin
          state_nxt     = GRANT1;
          burst_cnt_nxt = '0;
          rr_last_nxt   = 1'b1;
        end
      end
      GRANT0: begin
        grant      = 2'b01;
        busy       = 1'b1;
        tx_valid   = req0_valid;
        tx_data    = req0_data;
        req0_ready = tx_ready;
        xfer       = req0_valid && tx_ready;
        xfer_last  = req0_last;
      end
      GRANT1: begin
        grant      = 2'b10;
        busy       = 1'b1;
        tx_valid   = req1_valid;
        tx_data    = req1_data;
        req1_ready = tx_ready;
        xfer       = req1_valid && tx_ready;
        xfer_last  = req1_last;
      end
      default: state_nxt = IDLE;
    endcase

    // Last byte and burst cap landing on the same transfer give a single release.
    if (xfer) begin
      burst_cnt_nxt = burst_cnt + 1'b1;
      if (xfer_last || (burst_cnt_nxt == MAX_CNT)) begin
        state_nxt = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, each cycle
// compared against a cycle-level reference model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic              req0_valid, req0_last, req0_ready;
  logic              req1_valid, req1_last, req1_ready;
  logic [DATA_W-1:0] req0_data, req1_data, tx_data;
  logic              tx_valid, tx_ready, busy;
  logic [1:0]        grant;

  always #5 clk_clk = ~clk_clk;

  uart_tx_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_last    (req0_last),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_last    (req1_last),
    .req1_ready   (req1_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .grant        (grant),
    .busy         (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Source queues hold {last, byte}; a source pops its head on an observed handshake.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit         en0, en1, txr, rst_drv, chk_en;

  // Reference model: owner -1 means nobody holds the channel.
  int m_owner, m_served, m_last;

  logic [8:0] xfer_log[$];
  logic [1:0] grant_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic chk_log(input string tag, input logic [8:0] want[$]);
    chk($sformatf("%s_count", tag), 32'(xfer_log.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < xfer_log.size(); i++)
      chk($sformatf("%s_xfer%0d", tag, i), 32'(xfer_log[i]), 32'(want[i]));
  endtask

  task automatic add_pkt(input int src, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      logic [8:0] e;
      e = {(i == len - 1), 8'(base + 8'(i))};
      if (src == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
  endtask

  task automatic cycle();
    logic       v [2];
    logic       l [2];
    logic [7:0] d [2];
    logic [1:0] e_grant;
    @(negedge clk_clk);
    v[0] = en0 && (q0.size() != 0);
    v[1] = en1 && (q1.size() != 0);
    {l[0], d[0]} = (q0.size() != 0) ? q0[0] : 9'h000;
    {l[1], d[1]} = (q1.size() != 0) ? q1[0] : 9'h000;
    req0_valid = v[0]; req0_data = d[0]; req0_last = l[0];
    req1_valid = v[1]; req1_data = d[1]; req1_last = l[1];
    tx_ready      = txr;
    reset_reset_n = rst_drv;
    #1;
    if (chk_en) begin
      e_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
      chk("grant", 32'(grant), 32'(e_grant));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("tx_valid", 32'(tx_valid), 32'((m_owner >= 0) ? v[m_owner] : 1'b0));
      chk("req0_ready", 32'(req0_ready), 32'((m_owner == 0) ? txr : 1'b0));
      chk("req1_ready", 32'(req1_ready), 32'((m_owner == 1) ? txr : 1'b0));
      if (m_owner < 0)       chk("tx_data_idle", 32'(tx_data), 32'(0));
      else if (v[m_owner])   chk("tx_data", 32'(tx_data), 32'(d[m_owner]));
    end
    grant_log.push_back(grant);
    if (tx_valid && tx_ready) xfer_log.push_back({grant[1], tx_data});
    if (req0_valid && req0_ready) void'(q0.pop_front());
    if (req1_valid && req1_ready) void'(q1.pop_front());

    if (!rst_drv) begin
      m_owner = -1; m_served = 0; m_last = 1;
    end else if (m_owner < 0) begin
      if (v[0] && v[1]) m_owner = (m_last == 0) ? 1 : 0;
      else if (v[0])    m_owner = 0;
      else if (v[1])    m_owner = 1;
      if (m_owner >= 0) begin m_last = m_owner; m_served = 0; end
    end else if (v[m_owner] && txr) begin
      m_served++;
      if (l[m_owner] || m_served == MAX_BURST) m_owner = -1;
    end
    @(posedge clk_clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete();
    en0 = 0; en1 = 0; txr = 1;
    rst_drv = 0;
    cycle();
    chk_en  = 1;
    cycle();
    rst_drv = 1;
    xfer_log.delete(); grant_log.delete();
  endtask

  initial begin
    logic [8:0] want[$];
    logic [1:0] gseq[6];
    m_owner = -1; m_served = 0; m_last = 1;
    chk_en = 0; en0 = 0; en1 = 0; txr = 1; rst_drv = 0;

    // Single packet from req0.
    do_reset();
    chk("reset_grant", 32'(grant), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    add_pkt(0, 3, 8'h41); en0 = 1;
    run(6);
    want = '{9'h041, 9'h042, 9'h043};
    chk_log("single", want);
    chk("single_g0", 32'(grant_log[0]), 32'(2'b00));
    chk("single_g1", 32'(grant_log[1]), 32'(2'b01));
    chk("single_g4", 32'(grant_log[4]), 32'(2'b00));

    // Contention with 1-byte packets: grants alternate with a bubble between.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      add_pkt(0, 1, 8'(8'h50 + 8'(i)));
      add_pkt(1, 1, 8'(8'h60 + 8'(i)));
    end
    en0 = 1; en1 = 1;
    run(8);
    gseq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    for (int i = 0; i < 6; i++) chk($sformatf("rr_g%0d", i), 32'(grant_log[i]), 32'(gseq[i]));

    // Burst cap: req1 10-byte packet split after MAX_BURST, req0 served in between.
    do_reset();
    add_pkt(1, 10, 8'h10); en1 = 1;
    cycle();
    add_pkt(0, 2, 8'hA0); en0 = 1;
    run(22);
    want = '{9'h110, 9'h111, 9'h112, 9'h113, 9'h0A0, 9'h0A1,
             9'h114, 9'h115, 9'h116, 9'h117, 9'h118, 9'h119};
    chk_log("burst", want);

    // Backpressure mid-packet.
    do_reset();
    add_pkt(0, 5, 8'h30); en0 = 1;
    run(2);
    txr = 0; run(5);
    txr = 1; run(8);
    want = '{9'h030, 9'h031, 9'h032, 9'h033, 9'h034};
    chk_log("bp", want);

    // Owner stall: req0 drops valid while req1 waits.
    do_reset();
    add_pkt(0, 4, 8'h70); add_pkt(1, 2, 8'h80); en0 = 1;
    run(2);
    en0 = 0; en1 = 1; run(7);
    en0 = 1; run(12);
    want = '{9'h070, 9'h071, 9'h072, 9'h073, 9'h180, 9'h181};
    chk_log("stall", want);

    // Reset during byte 2 of a req1 packet.
    do_reset();
    add_pkt(1, 4, 8'h90); en1 = 1;
    run(2);
    rst_drv = 0; cycle();
    rst_drv = 1;
    xfer_log.delete(); grant_log.delete();
    add_pkt(0, 1, 8'hB0); en0 = 1;
    run(4);
    chk("rst_g0", 32'(grant_log[0]), 32'(2'b00));
    chk("rst_first", 32'(xfer_log.size() > 0 ? xfer_log[0] : 9'h1FF), 32'(9'h0B0));

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (q0.size() < 3) add_pkt(0, int'($urandom_range(1, 7)), 8'($urandom));
      if (q1.size() < 3) add_pkt(1, int'($urandom_range(1, 7)), 8'($urandom));
      en0 = ($urandom_range(0, 3) != 0);
      en1 = ($urandom_range(0, 3) != 0);
      txr = ($urandom_range(0, 4) != 0);
      rst_drv = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
